// File: rtl/efuse_seq_ctrl.sv
// eFuse top-level sequencer: auto-loads all words into shadow registers after reset,
// then arbitrates single-word software reads and key-protected programs with read-back verify.
module efuse_seq_ctrl #(
  parameter int          NW         = 64,
  parameter int          WSEL       = 256 / NW,
  parameter int          TMO_W      = 16,
  parameter logic [31:0] UNLOCK_KEY = 32'hA5C3_5A3C
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              rg_efuse_unlock,
  input  logic [$clog2(WSEL)-1:0]  sw_sel,
  input  logic [NW-1:0]            sw_wdata,
  input  logic                     sw_rd_req,
  input  logic                     sw_wr_req,
  output logic                     sw_ack,
  output logic                     sw_err,
  output logic [1:0]               sw_err_code,
  output logic                     busy,
  output logic                     load_done,
  output logic                     load_err,
  output logic [NW*WSEL-1:0]       shadow_data,
  output logic [$clog2(WSEL)-1:0]  write_sel,
  output logic [NW-1:0]            write_data,
  output logic                     write_start,
  input  logic                     write_done,
  input  logic                     busy_write,
  output logic [$clog2(WSEL)-1:0]  read_sel,
  output logic                     read_start,
  input  logic                     read_done,
  input  logic [NW-1:0]            read_data
);

  localparam int SW = $clog2(WSEL);

  typedef enum logic [3:0] {
    AL_START, AL_WAIT, IDLE, RD_START, RD_WAIT, WR_START, WR_WAIT, VF_START, VF_WAIT
  } state_t;

  localparam logic [1:0] CODE_LOCKED = 2'b01;
  localparam logic [1:0] CODE_BUSY   = 2'b10;
  localparam logic [1:0] CODE_FAIL   = 2'b11;

  state_t                   r_state;
  logic [SW-1:0]            r_idx;
  logic [TMO_W-1:0]         r_tmo;
  logic [WSEL-1:0][NW-1:0]  r_shadow;
  logic                     r_ack;
  logic                     r_err;
  logic [1:0]               r_code;
  logic                     r_err_pend;
  logic                     r_busy;
  logic                     r_load_done;
  logic                     r_load_err;
  logic [SW-1:0]            r_write_sel;
  logic [NW-1:0]            r_write_data;
  logic                     r_write_start;
  logic [SW-1:0]            r_read_sel;
  logic                     r_read_start;

  logic w_tmo;
  logic w_req;
  logic w_last;
  logic w_verify_ok;
  logic w_resp;

  assign w_tmo       = (r_tmo == '1);
  assign w_req       = sw_rd_req | sw_wr_req;
  assign w_last      = (r_idx == SW'(WSEL - 1));
  assign w_verify_ok = ((read_data & r_write_data) == r_write_data);

  // A software response is produced this cycle by the FSM itself.
  always_comb begin
    w_resp = 1'b0;
    case (r_state)
      RD_WAIT, VF_WAIT: w_resp = read_done | w_tmo;
      WR_WAIT:          w_resp = ~write_done & w_tmo;
      default:          w_resp = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= AL_START;
      r_idx         <= '0;
      r_tmo         <= '0;
      r_shadow      <= '0;
      r_ack         <= 1'b0;
      r_err         <= 1'b0;
      r_code        <= '0;
      r_err_pend    <= 1'b0;
      r_busy        <= 1'b0;
      r_load_done   <= 1'b0;
      r_load_err    <= 1'b0;
      r_write_sel   <= '0;
      r_write_data  <= '0;
      r_write_start <= 1'b0;
      r_read_sel    <= '0;
      r_read_start  <= 1'b0;
    end else begin
      r_ack         <= 1'b0;
      r_err         <= 1'b0;
      r_read_start  <= 1'b0;
      r_write_start <= 1'b0;

      // A stray request colliding with a completion is reported one cycle later.
      if (r_state != IDLE && w_req) begin
        if (w_resp) begin
          r_err_pend <= 1'b1;
        end else begin
          r_err  <= 1'b1;
          r_code <= CODE_BUSY;
        end
      end

      case (r_state)
        AL_START: begin
          r_read_sel   <= r_idx;
          r_read_start <= 1'b1;
          r_tmo        <= '0;
          r_busy       <= 1'b1;
          r_state      <= AL_WAIT;
        end
        AL_WAIT: begin
          if (read_done || w_tmo) begin
            if (read_done) r_shadow[r_idx] <= read_data;
            else           r_load_err      <= 1'b1;
            if (w_last) begin
              r_load_done <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= IDLE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= AL_START;
            end
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        IDLE: begin
          if (r_err_pend) begin
            r_err      <= 1'b1;
            r_code     <= CODE_BUSY;
            r_err_pend <= w_req;
          end else if (sw_rd_req) begin
            r_read_sel <= sw_sel;
            r_busy     <= 1'b1;
            r_state    <= RD_START;
            if (sw_wr_req) begin
              r_err  <= 1'b1;
              r_code <= CODE_BUSY;
            end
          end else if (sw_wr_req) begin
            if (rg_efuse_unlock == UNLOCK_KEY) begin
              r_write_sel  <= sw_sel;
              r_write_data <= sw_wdata;
              r_read_sel   <= sw_sel;
              r_busy       <= 1'b1;
              r_state      <= WR_START;
            end else begin
              r_err  <= 1'b1;
              r_code <= CODE_LOCKED;
            end
          end
        end
        RD_START, VF_START: begin
          r_read_start <= 1'b1;
          r_tmo        <= '0;
          r_state      <= (r_state == RD_START) ? RD_WAIT : VF_WAIT;
        end
        RD_WAIT: begin
          if (read_done) begin
            r_shadow[r_read_sel] <= read_data;
            r_ack                <= 1'b1;
            r_busy               <= 1'b0;
            r_state              <= IDLE;
          end else if (w_tmo) begin
            r_err   <= 1'b1;
            r_code  <= CODE_FAIL;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        WR_START: begin
          if (!busy_write) begin
            r_write_start <= 1'b1;
            r_tmo         <= '0;
            r_state       <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (write_done) begin
            r_state <= VF_START;
          end else if (w_tmo) begin
            r_err   <= 1'b1;
            r_code  <= CODE_FAIL;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        VF_WAIT: begin
          if (read_done) begin
            r_shadow[r_read_sel] <= read_data;
            if (w_verify_ok) begin
              r_ack <= 1'b1;
            end else begin
              r_err  <= 1'b1;
              r_code <= CODE_FAIL;
            end
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (w_tmo) begin
            r_err   <= 1'b1;
            r_code  <= CODE_FAIL;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign sw_ack      = r_ack;
  assign sw_err      = r_err;
  assign sw_err_code = r_code;
  assign busy        = r_busy;
  assign load_done   = r_load_done;
  assign load_err    = r_load_err;
  assign shadow_data = r_shadow;
  assign write_sel   = r_write_sel;
  assign write_data  = r_write_data;
  assign write_start = r_write_start;
  assign read_sel    = r_read_sel;
  assign read_start  = r_read_start;

endmodule

// File: doc/efuse_seq_ctrl.md
Name: efuse_seq_ctrl

Overview:
Top-level sequencer for the eFuse macro. It owns the efuse_write engine and a companion read engine, and decides which one may touch the macro. After reset it auto-loads every word into shadow registers. It then serves single-word software read and program requests, with an unlock key, a read-back check after every program, and timeout protection.

Parameters:
NW, 64, bits per eFuse word
WSEL, 256/NW, number of words (4 by default)
TMO_W, 16, width of the engine-timeout counter
UNLOCK_KEY, 32'hA5C3_5A3C, value rg_efuse_unlock must hold to allow programming

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous assert, active-low
rg_efuse_unlock  in  32  program unlock key register
sw_sel  in  $clog2(WSEL)  software word index
sw_wdata  in  NW  software program data
sw_rd_req  in  1  one-cycle read request pulse
sw_wr_req  in  1  one-cycle program request pulse
sw_ack  out  1  one-cycle pulse: request completed without error
sw_err  out  1  one-cycle pulse: request rejected or failed
sw_err_code  out  2  01 locked, 10 busy, 11 fail (timeout or verify); holds last value
busy  out  1  high in every state except IDLE
load_done  out  1  sticky; set when auto-load finishes
load_err  out  1  sticky; set if any auto-load read timed out
shadow_data  out  NW*WSEL  shadow copy; word i at [i*NW +: NW]
write_sel  out  $clog2(WSEL)  write engine word index
write_data  out  NW  write engine data
write_start  out  1  write engine start pulse
write_done  in  1  write engine completion pulse
busy_write  in  1  write engine busy
read_sel  out  $clog2(WSEL)  read engine word index
read_start  out  1  read engine start pulse
read_done  in  1  read engine completion pulse
read_data  in  NW  read engine data, valid with read_done

Behaviour:
- Reset values: all outputs 0, shadow_data 0, state AL_START, load index 0, timeout counter 0.
- Reset asserted mid-operation aborts everything; auto-load restarts from word 0 after release.
- States: AL_START, AL_WAIT, IDLE, RD_START, RD_WAIT, WR_START, WR_WAIT, VF_START, VF_WAIT.
- START states: issue a one-cycle read_start or write_start, clear the timeout counter, and go to the matching WAIT state next cycle. write_start is issued only when busy_write=0; otherwise stay in WR_START.
- sel/data outputs are registered and stable from the start pulse until done.
- AL_WAIT, on read_done:
  - shadow[idx] <= read_data.
  - If idx == WSEL-1: set load_done, go to IDLE.
  - Else: idx++, go to AL_START.
- IDLE: requests are sampled only here.
  - sw_rd_req: latch sw_sel, go to RD_START.
  - sw_wr_req with rg_efuse_unlock == UNLOCK_KEY: latch sw_sel and sw_wdata, go to WR_START.
  - sw_wr_req while locked: sw_err with code 01 next cycle; no engine activity.
  - sw_rd_req and sw_wr_req in the same cycle: the read is served; the write is rejected with code 10.
- Any sw_*_req outside IDLE (including during auto-load): sw_err with code 10 next cycle; state unaffected.
- RD_WAIT, on read_done: shadow[sel] <= read_data; sw_ack the next cycle; go to IDLE.
- WR_WAIT, on write_done: go to VF_START. The word is re-read on read_sel = latched sel.
- VF_WAIT, on read_done:
  - Shadow is always updated with read_data.
  - If (read_data & wdata) == wdata: sw_ack.
  - Else: sw_err with code 11.
  - Go to IDLE either way.
- Timeout: in any WAIT state the counter increments each cycle. At all-ones:
  - Abandon the operation.
  - sw_err code 11, or set load_err and skip the word during auto-load (shadow word stays 0).
  - Continue to the next step / IDLE.
- A done pulse arriving in a non-WAIT state is ignored.
- sw_ack and sw_err never assert in the same cycle.

Test Plan:
- Release reset; read engine returns 64'h11, 22, 33, 44 for words 0..3 -> shadow_data = {44,33,22,11} (word 0 at LSB); load_done=1, load_err=0; no sw_ack.
- Unlock = UNLOCK_KEY; sw_wr_req with sel=2, wdata=64'h34; write_done; read-back = 64'h34 -> exactly one write_start with write_sel=2; one read_start with read_sel=2; sw_ack; shadow word 2 = 64'h34.
- Same write, but read-back = 64'h30 -> sw_err with sw_err_code=11; shadow word 2 = 64'h30.
- Unlock = 0; sw_wr_req -> sw_err with code 01 one cycle later; write_start never pulses; busy stays 0.
- sw_rd_req and sw_wr_req in the same cycle while idle -> read served with sw_ack; sw_err code 10 for the write. Separately, sw_rd_req during auto-load -> sw_err code 10.
- Read engine never returns read_done on word 1 during auto-load -> timeout after 2^TMO_W-1 cycles; load_err=1; word 1 stays 0; words 2..3 still load; load_done=1. Then assert rst_n low mid-WR_WAIT -> all outputs 0 immediately and auto-load restarts.
